branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Program-counter and branch-resolution stage of KGP-RISC, sitting directly downstream of the ALU. It sequences each instruction through fetch request, fetch wait and execute-resolve states. In the resolve cycle it consumes the ALU zero and sign flags plus the ALU's registered carry flag. It then decides the next PC, emits the link-register write for `bl`, and counts retired instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential increment in bytes
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- instr_valid  in  1  instruction memory returns the word requested at `pc`; honoured only in WAIT
- exec_done  in  1  execute stage of the current instruction has finished and flags are valid; honoured only in EXEC
- branch_op  in  4  decoded control-transfer type, sampled with exec_done
- target  in  32  absolute branch target for L-type branches, byte address
- rs_val  in  32  register value for `br`
- zero_flag  in  1  ALU zeroFlag (ALU driven with op 1000/0111 on rs for `bz`/`bnz`/`bltz`)
- sign_flag  in  1  ALU signFlag
- carry_flag  in  1  ALU registered carry, last `add` result
- halt  in  1  current instruction is a halt; sampled with exec_done
- pc  out  32  current instruction address
- fetch_req  out  1  request instruction at `pc`
- link_we  out  1  one-cycle write strobe for r31
- link_addr  out  32  `pc`+PC_STEP of the `bl` that produced `link_we`
- branch_taken  out  1  one-cycle pulse: last resolved instruction redirected the PC
- halted  out  1  unit stopped
- misalign_err  out  1  stopped because of a misaligned taken target
- retire_count  out  32  instructions retired since reset

## Operation
- branch_op encoding and taken condition:
  - 0000: none, never taken.
  - 0001 `b`: always taken, target.
  - 0010 `br`: always taken, rs_val.
  - 0011 `bl`: always taken, target, link.
  - 0100 `bcy`: taken if carry_flag=1.
  - 0101 `bncy`: taken if carry_flag=0.
  - 0110 `bltz`: taken if sign_flag=1.
  - 0111 `bz`: taken if zero_flag=1.
  - 1000 `bnz`: taken if zero_flag=0.
  - 1001-1111: treated as 0000.
- FSM states: FETCH, WAIT, EXEC, HALT. Moore outputs: fetch_req=1 only in FETCH; halted=1 only in HALT.
- FETCH -> WAIT unconditionally after one cycle.
- WAIT -> EXEC on instr_valid; otherwise stay in WAIT.
- EXEC stays in EXEC until exec_done. On exec_done, precedence is halt > misaligned taken > normal:
  - halt=1: go to HALT. pc is unchanged, retire_count +1, no link, no branch_taken.
  - Taken with destination[1:0]≠0: go to HALT. misalign_err=1, pc unchanged, retire_count unchanged, no link.
  - Otherwise: pc <= taken ? destination : pc+PC_STEP, retire_count +1, next state FETCH.
  - branch_taken=1 for one cycle if the branch was taken. For `bl`, link_we=1 for one cycle with link_addr=old pc+PC_STEP.
- HALT is left only by reset.
- Width rules:
  - pc+PC_STEP and retire_count wrap modulo 2^32. FFFF_FFFC+4 gives 0000_0000, and that is not an error.
  - Destination alignment is checked only for taken branches.
- Inputs are ignored outside their honoured state: exec_done outside EXEC, instr_valid outside WAIT, branch_op/halt without exec_done.

## Timing
- Reset values (immediate on assert, asynchronous):
  - pc=RESET_PC, state=FETCH.
  - fetch_req=1, since it decodes from the state.
  - link_we=0, link_addr=0, branch_taken=0, halted=0, misalign_err=0, retire_count=0.
- Minimum instruction period is 3 cycles, when instr_valid and exec_done are each high on the first cycle of their state.
- pc, link_we, link_addr, branch_taken and retire_count update on the edge that leaves EXEC. They are visible in the following FETCH cycle.
- link_we and branch_taken are cleared on the next edge.
- Flags are sampled combinationally in the exec_done cycle. The carry used is the value registered before that edge.
- Reset asserted mid-instruction (any state) aborts the instruction with no link write and no count.

## Test plan
- Reset, then RESET_PC=0. Give instr_valid on the first WAIT cycle and exec_done on the first EXEC cycle with branch_op=0000, three times -> pc 0,4,8,12; retire_count=3; fetch_req high every third cycle.
- pc=0x10, `bl` with target=0x40 -> pc=0x40; link_we pulse with link_addr=0x14; branch_taken pulse for exactly 1 cycle.
- `bcy` with carry_flag=0, then `bncy` with carry_flag=0 and target=0x80 -> first gives pc+4 with branch_taken=0; second gives pc=0x80.
- `bz` with zero_flag=1 and target=0x22 -> HALT; misalign_err=1; pc and retire_count unchanged. Repeat with zero_flag=0 -> pc+4, no error.
- pc=FFFF_FFFC with branch_op=0000 -> pc=0000_0000, no error. Then halt=1 -> halted=1, retire_count +1; further exec_done and instr_valid are ignored.
- Assert reset during WAIT and again during EXEC with exec_done=1 in the same cycle -> all outputs return to reset values, no link_we and no count.

Source files
------------

// File: rtl/branch_pc_unit.sv
// ----------------------------------------------------------------------------
// branch_pc_unit
//
// Program-counter and branch-resolution stage of KGP-RISC. Each instruction
// walks FETCH -> WAIT -> EXEC. In the EXEC cycle that carries exec_done, the
// unit does four things:
//   - resolves the decoded control transfer against the ALU flags,
//   - picks the next PC,
//   - emits the r31 link write for `bl`,
//   - counts the retired instruction.
// A halt instruction or a misaligned taken target parks the unit in HALT.
// Only reset leaves HALT.
//
// Parameters
//   RESET_PC      PC value loaded on reset
//   PC_STEP       sequential increment in bytes
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high
//   instr_valid   instruction word for pc is available (honoured in WAIT)
//   exec_done     execute finished, flags valid (honoured in EXEC)
//   branch_op     decoded control-transfer type, sampled with exec_done
//   target        absolute L-type branch target (byte address)
//   rs_val        register value used by `br`
//   zero_flag     ALU zero flag
//   sign_flag     ALU sign flag
//   carry_flag    ALU registered carry of the last add
//   halt          current instruction is a halt, sampled with exec_done
//   pc            current instruction address
//   fetch_req     request instruction at pc (high only in FETCH)
//   link_we       one-cycle r31 write strobe
//   link_addr     return address (old pc + PC_STEP) of the `bl`
//   branch_taken  one-cycle pulse: last resolved instruction redirected pc
//   halted        unit stopped (high only in HALT)
//   misalign_err  stopped because of a misaligned taken target
//   retire_count  instructions retired since reset
// ----------------------------------------------------------------------------
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic        exec_done,
  input  logic [3:0]  branch_op,
  input  logic [31:0] target,
  input  logic [31:0] rs_val,
  input  logic        zero_flag,
  input  logic        sign_flag,
  input  logic        carry_flag,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        fetch_req,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        branch_taken,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] retire_count
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [31:0] STEP_W = 32'(PC_STEP);

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_B    = 4'b0001;
  localparam logic [3:0] OP_BR   = 4'b0010;
  localparam logic [3:0] OP_BL   = 4'b0011;
  localparam logic [3:0] OP_BCY  = 4'b0100;
  localparam logic [3:0] OP_BNCY = 4'b0101;
  localparam logic [3:0] OP_BLTZ = 4'b0110;
  localparam logic [3:0] OP_BZ   = 4'b0111;
  localparam logic [3:0] OP_BNZ  = 4'b1000;

  // Taken condition for each control-transfer type; unused encodings act as "none".
  function automatic logic resolve_taken(input logic [3:0] op,
                                         input logic       zf,
                                         input logic       sf,
                                         input logic       cf);
    logic tk;
    case (op)
      OP_NONE: tk = 1'b0;
      OP_B:    tk = 1'b1;
      OP_BR:   tk = 1'b1;
      OP_BL:   tk = 1'b1;
      OP_BCY:  tk = cf;
      OP_BNCY: tk = ~cf;
      OP_BLTZ: tk = sf;
      OP_BZ:   tk = zf;
      OP_BNZ:  tk = ~zf;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  // Destination of a taken branch: register-indirect for `br`, absolute otherwise.
  function automatic logic [31:0] resolve_dest(input logic [3:0]  op,
                                               input logic [31:0] tgt,
                                               input logic [31:0] rs);
    logic [31:0] d;
    case (op)
      OP_BR:   d = rs;
      default: d = tgt;
    endcase
    return d;
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] pc_r;
  logic        fetch_req_r;
  logic        link_we_r;
  logic [31:0] link_addr_r;
  logic        branch_taken_r;
  logic        halted_r;
  logic        misalign_err_r;
  logic [31:0] retire_count_r;

  logic        taken_s;
  logic [31:0] dest_s;
  logic [31:0] pc_plus_s;
  logic        misalign_s;
  logic        is_bl_s;
  logic        commit_s;   // normal completion: pc redirect/advance, maybe link
  logic        retire_s;   // retire counter increments
  logic        fault_s;    // misaligned taken target stops the unit

  assign taken_s    = resolve_taken(branch_op, zero_flag, sign_flag, carry_flag);
  assign dest_s     = resolve_dest(branch_op, target, rs_val);
  assign pc_plus_s  = pc_r + STEP_W;   // wraps modulo 2^32 by construction
  // Alignment only matters when the branch actually redirects.
  assign misalign_s = taken_s & (dest_s[1:0] != 2'b00);
  assign is_bl_s    = (branch_op == OP_BL);

  // Next-state and completion decode: halt beats misalignment beats normal retire.
  always_comb begin
    state_next_s = state_r;
    commit_s     = 1'b0;
    retire_s     = 1'b0;
    fault_s      = 1'b0;
    case (state_r)
      ST_FETCH: begin
        state_next_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (instr_valid) begin
          state_next_s = ST_EXEC;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          if (halt) begin
            state_next_s = ST_HALT;
            retire_s     = 1'b1;
          end else if (misalign_s) begin
            state_next_s = ST_HALT;
            fault_s      = 1'b1;
          end else begin
            state_next_s = ST_FETCH;
            commit_s     = 1'b1;
            retire_s     = 1'b1;
          end
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_FETCH;
      end
    endcase
  end

  // State register plus registered Moore decodes of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_FETCH;
      fetch_req_r <= 1'b1;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      fetch_req_r <= (state_next_s == ST_FETCH);
      halted_r    <= (state_next_s == ST_HALT);
    end
  end

  // Architectural PC: only a normal completion moves it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (commit_s) begin
      pc_r <= taken_s ? dest_s : pc_plus_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // One-cycle strobes; rewritten every cycle so they self-clear on the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_we_r      <= 1'b0;
      branch_taken_r <= 1'b0;
    end else begin
      link_we_r      <= commit_s & is_bl_s;
      branch_taken_r <= commit_s & taken_s;
    end
  end

  // Return address held until the next `bl` completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_addr_r <= 32'h0000_0000;
    end else if (commit_s && is_bl_s) begin
      link_addr_r <= pc_plus_s;
    end else begin
      link_addr_r <= link_addr_r;
    end
  end

  // Retired-instruction counter, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_count_r <= 32'h0000_0000;
    end else if (retire_s) begin
      retire_count_r <= retire_count_r + 32'd1;
    end else begin
      retire_count_r <= retire_count_r;
    end
  end

  // Sticky misalignment flag; HALT is left only through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_err_r <= 1'b0;
    end else if (fault_s) begin
      misalign_err_r <= 1'b1;
    end else begin
      misalign_err_r <= misalign_err_r;
    end
  end

  assign pc           = pc_r;
  assign fetch_req    = fetch_req_r;
  assign link_we      = link_we_r;
  assign link_addr    = link_addr_r;
  assign branch_taken = branch_taken_r;
  assign halted       = halted_r;
  assign misalign_err = misalign_err_r;
  assign retire_count = retire_count_r;

endmodule

// File: tb/tb_branch_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_pc_unit
//
// Table-driven bench for branch_pc_unit. Each record holds one instruction's
// inputs, its WAIT/EXEC stall lengths, and the expected outputs after it
// resolves. Each record's expectation is pushed to a scoreboard queue when
// exec_done is driven. It is popped and compared once the DUT leaves EXEC.
// Hand-written sequences cover:
//   - ignored inputs while halted,
//   - reset asserted in the middle of an instruction.
// ----------------------------------------------------------------------------
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        exec_done;
  logic [3:0]  branch_op;
  logic [31:0] target;
  logic [31:0] rs_val;
  logic        zero_flag;
  logic        sign_flag;
  logic        carry_flag;
  logic        halt;
  logic [31:0] pc;
  logic        fetch_req;
  logic        link_we;
  logic [31:0] link_addr;
  logic        branch_taken;
  logic        halted;
  logic        misalign_err;
  logic [31:0] retire_count;

  int checks   = 0;
  int failures = 0;

  branch_pc_unit dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .branch_op    (branch_op),
    .target       (target),
    .rs_val       (rs_val),
    .zero_flag    (zero_flag),
    .sign_flag    (sign_flag),
    .carry_flag   (carry_flag),
    .halt         (halt),
    .pc           (pc),
    .fetch_req    (fetch_req),
    .link_we      (link_we),
    .link_addr    (link_addr),
    .branch_taken (branch_taken),
    .halted       (halted),
    .misalign_err (misalign_err),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] tgt;
    logic [31:0] rs;
    logic        z;
    logic        s;
    logic        c;
    logic        h;
    int          wait_n;
    int          exec_n;
    logic [31:0] e_pc;
    logic        e_taken;
    logic        e_link;
    logic [31:0] e_link_addr;
    logic        e_halted;
    logic        e_mis;
    logic [31:0] e_retire;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        link;
    logic [31:0] link_addr;
    logic        halted;
    logic        mis;
    logic [31:0] retire;
  } exp_t;

  vec_t vecs[23];
  exp_t sb[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] tgt, input logic [31:0] rs,
                              input logic z, input logic s, input logic c, input logic h,
                              input int wn, input int en,
                              input logic [31:0] epc, input logic et, input logic el,
                              input logic [31:0] ela, input logic eh, input logic em,
                              input logic [31:0] er);
    vec_t v;
    v.op = op; v.tgt = tgt; v.rs = rs; v.z = z; v.s = s; v.c = c; v.h = h;
    v.wait_n = wn; v.exec_n = en;
    v.e_pc = epc; v.e_taken = et; v.e_link = el; v.e_link_addr = ela;
    v.e_halted = eh; v.e_mis = em; v.e_retire = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_valid = 1'b0; exec_done = 1'b0; branch_op = 4'b0000;
    target = 32'h0; rs_val = 32'h0; zero_flag = 1'b0; sign_flag = 1'b0;
    carry_flag = 1'b0; halt = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " pc"}, pc, 32'h0000_0000);
    chk({tag, " fetch_req"}, 32'(fetch_req), 32'd1);
    chk({tag, " link_we"}, 32'(link_we), 32'd0);
    chk({tag, " link_addr"}, link_addr, 32'h0);
    chk({tag, " branch_taken"}, 32'(branch_taken), 32'd0);
    chk({tag, " halted"}, 32'(halted), 32'd0);
    chk({tag, " misalign_err"}, 32'(misalign_err), 32'd0);
    chk({tag, " retire_count"}, retire_count, 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Drive one instruction through FETCH/WAIT/EXEC and score its result.
  task automatic run_instr(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    int   n;
    n = 0;
    while (fetch_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk({tag, " fetch_req in FETCH"}, 32'(fetch_req), 32'd1);
    step();
    // Now in WAIT: previous strobes must have cleared.
    chk({tag, " fetch_req low in WAIT"}, 32'(fetch_req), 32'd0);
    chk({tag, " link_we cleared"}, 32'(link_we), 32'd0);
    chk({tag, " branch_taken cleared"}, 32'(branch_taken), 32'd0);
    // Stall in WAIT with exec_done/halt asserted: they must be ignored.
    for (int i = 0; i < v.wait_n; i++) begin
      exec_done = 1'b1; halt = 1'b1; branch_op = 4'b0001; target = 32'h0000_0F00;
      step();
    end
    exec_done = 1'b0; halt = 1'b0; branch_op = 4'b0000;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    // Stall in EXEC with halt/branch_op/instr_valid but no exec_done.
    for (int i = 0; i < v.exec_n; i++) begin
      halt = 1'b1; branch_op = 4'b0001; target = 32'h0000_0F00; instr_valid = 1'b1;
      step();
    end
    instr_valid = 1'b0;
    branch_op = v.op; target = v.tgt; rs_val = v.rs;
    zero_flag = v.z; sign_flag = v.s; carry_flag = v.c; halt = v.h;
    exec_done = 1'b1;
    e.pc = v.e_pc; e.taken = v.e_taken; e.link = v.e_link; e.link_addr = v.e_link_addr;
    e.halted = v.e_halted; e.mis = v.e_mis; e.retire = v.e_retire;
    sb.push_back(e);
    step();
    idle_inputs();
    got.pc = pc; got.taken = branch_taken; got.link = link_we; got.link_addr = link_addr;
    got.halted = halted; got.mis = misalign_err; got.retire = retire_count;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, " pc"}, got.pc, e.pc);
      chk({tag, " branch_taken"}, 32'(got.taken), 32'(e.taken));
      chk({tag, " link_we"}, 32'(got.link), 32'(e.link));
      if (e.link) begin
        chk({tag, " link_addr"}, got.link_addr, e.link_addr);
      end
      chk({tag, " halted"}, 32'(got.halted), 32'(e.halted));
      chk({tag, " misalign_err"}, 32'(got.mis), 32'(e.mis));
      chk({tag, " retire_count"}, got.retire, e.retire);
      chk({tag, " fetch_req after"}, 32'(fetch_req), 32'(!e.halted));
    end
  endtask

  initial begin
    //           op      tgt           rs            z     s     c     h   w  e  pc            tk    lk    laddr         hlt   mis   ret
    vecs[0]  = mk(4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'd1);
    vecs[1]  = mk(4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0008, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'd2);
    vecs[2]  = mk(4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_000C, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'd3);
    vecs[3]  = mk(4'h1, 32'h10,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1, 2, 32'h0000_0010, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'd4);
    vecs[4]  = mk(4'h3, 32'h40,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 32'h0000_0040, 1'b1, 1'b1, 32'h14,       1'b0, 1'b0, 32'd5);
    vecs[5]  = mk(4'h4, 32'h100,      32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 32'h0000_0044, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'd6);
    vecs[6]  = mk(4'h5, 32'h80,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0080, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'd7);
    vecs[7]  = mk(4'h2, 32'h300,      32'h200,      1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 32'h0000_0200, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'd8);
    vecs[8]  = mk(4'h6, 32'h240,      32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0000_0240, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'd9);
    vecs[9]  = mk(4'h6, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0000_0244, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'd10);
    vecs[10] = mk(4'h8, 32'h500,      32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0248, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'd11);
    vecs[11] = mk(4'h8, 32'h500,      32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0500, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'd12);
    vecs[12] = mk(4'h7, 32'h22,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0504, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'd13);
    vecs[13] = mk(4'hA, 32'h3,        32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 32'h0000_0508, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'd14);
    vecs[14] = mk(4'h4, 32'h600,      32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0000_0600, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'd15);
    vecs[15] = mk(4'h2, 32'h0,        32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'd16);
    vecs[16] = mk(4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'd17);
    vecs[17] = mk(4'h1, 32'h40,       32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'd18);
    vecs[18] = mk(4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 32'h0000_0004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'd1);
    vecs[19] = mk(4'h7, 32'h22,       32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0004, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'd1);
    vecs[20] = mk(4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0004, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'd1);
    vecs[21] = mk(4'h1, 32'h8,        32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0008, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'd1);
    vecs[22] = mk(4'h3, 32'h42,       32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0008, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'd1);

    reset = 1'b1;
    idle_inputs();
    #1;
    check_reset("async reset");
    step();
    check_reset("reset");
    reset = 1'b0;

    // Straight-line, branch and wrap sequence ending in a halt.
    for (int i = 0; i <= 17; i++) begin
      run_instr(vecs[i], $sformatf("vec%0d", i));
    end

    // Once halted, further exec_done / instr_valid must change nothing.
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1; exec_done = 1'b1; branch_op = 4'b0001; target = 32'h40;
      step();
    end
    idle_inputs();
    chk("halted hold pc", pc, 32'h0);
    chk("halted hold retire", retire_count, 32'd18);
    chk("halted hold halted", 32'(halted), 32'd1);
    chk("halted hold fetch_req", 32'(fetch_req), 32'd0);
    chk("halted hold branch_taken", 32'(branch_taken), 32'd0);

    // Misaligned taken target stops the unit without retiring.
    do_reset();
    check_reset("reset2");
    for (int i = 18; i <= 19; i++) begin
      run_instr(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during WAIT and during EXEC (with exec_done in the same cycle).
    do_reset();
    run_instr(vecs[20], "vec20");
    step();                       // FETCH -> WAIT
    reset = 1'b1;
    #1;
    check_reset("reset in WAIT");
    step();
    reset = 1'b0;
    step();                       // FETCH -> WAIT
    instr_valid = 1'b1;
    step();                       // WAIT -> EXEC
    instr_valid = 1'b0;
    branch_op = 4'b0011; target = 32'h40; exec_done = 1'b1;
    reset = 1'b1;
    #1;
    check_reset("reset in EXEC");
    step();
    check_reset("reset in EXEC edge");
    idle_inputs();
    reset = 1'b0;
    for (int i = 21; i <= 22; i++) begin
      run_instr(vecs[i], $sformatf("vec%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
